// File: rtl/debounce_pkg.sv
// Shared state encodings and default sizing for the input debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b11,
        WAIT_LOW  = 2'b10
    } state_e;

    localparam int STABLE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF         = 3;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous bit; q lags d by two edges.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/debounce_sync.sv
// Synchronises and debounces a raw input into a clean level plus rise/fall strobes.
// dout/rise/fall move STABLE_CYCLES+1 edges after s1 first captures a new held level.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > (1 << CNT_W)) begin : g_param_check
        $error("debounce_sync: STABLE_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic       s2;
    state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       dout_q, dout_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    sync2 u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     (din),
        .q     (s2)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        unique case (state_q)
            IDLE_LOW: begin
                if (s2) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            // A revert wins over completion on the same edge.
            WAIT_HIGH: begin
                if (!s2) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!s2) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s2) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync at default sizing (STABLE_CYCLES=4).
module tb_debounce_sync;

    logic clk;
    logic reset;
    logic din;
    logic dout;
    logic rise;
    logic fall;

    int checks;
    int failures;

    debounce_sync dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .dout  (dout),
        .rise  (rise),
        .fall  (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {29'd0, dout, rise, fall};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        din      = 1'b0;

        // Reset then idle
        tick();
        tick();
        chk("reset_outs", outs(), 32'b000);
        chk("reset_state", 32'(dut.state_q), 32'b00);
        chk("reset_cnt", 32'(dut.cnt_q), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_outs", outs(), 32'b000);
        end

        // Clean rise: capture edge plus four more edges stay low, then pulse
        din = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rise_wait", outs(), 32'b000);
        end
        tick();
        chk("rise_pulse", outs(), 32'b110);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rise_hold", outs(), 32'b100);
        end

        // Clean fall
        din = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fall_wait", outs(), 32'b100);
        end
        tick();
        chk("fall_pulse", outs(), 32'b001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fall_hold", outs(), 32'b000);
        end

        // Glitch reject: three-cycle high pulse falls one short
        din = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("glitch_hi", outs(), 32'b000);
        end
        din = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("glitch_lo", outs(), 32'b000);
        end
        chk("glitch_state", 32'(dut.state_q), 32'b00);
        chk("glitch_cnt", 32'(dut.cnt_q), 32'd0);

        // Bounce then settle high
        for (int i = 0; i < 8; i++) begin
            din = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            chk("bounce", outs(), 32'b000);
        end
        din = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("settle_wait", outs(), 32'b000);
        end
        tick();
        chk("settle_pulse", outs(), 32'b110);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("settle_hold", outs(), 32'b100);
        end

        // Return low for the next scenario
        din = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("back_low", outs(), 32'b000);

        // Reset mid-wait at cnt=2
        din = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("midwait_cnt", 32'(dut.cnt_q), 32'd2);
        chk("midwait_state", 32'(dut.state_q), 32'b01);
        reset = 1'b1;
        tick();
        chk("midrst_outs", outs(), 32'b000);
        chk("midrst_cnt", 32'(dut.cnt_q), 32'd0);
        chk("midrst_state", 32'(dut.state_q), 32'b00);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("postrst_wait", outs(), 32'b000);
        end
        tick();
        chk("postrst_pulse", outs(), 32'b110);
        tick();
        chk("postrst_hold", outs(), 32'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
